sc_stream_decoder: RTL and testbench
====================================

Name: sc_stream_decoder

Overview:
- Stochastic-to-binary converter that sits directly downstream of the multivariate polynomial stochastic blocks.
- Counts the 1s in the single-bit output stream `z` over a programmable window of `len` valid bits and returns a binary estimate of the stream probability.
- Issues `stream_en` so the upstream polynomial block and its random-bit sources run only during a conversion.
- Start/busy/done handshake toward the control sequencer.

Parameters:
- CNT_W, 10, width of the window-length and bit counters; maximum window is 2^CNT_W-1 bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a conversion; sampled only in IDLE.
- abort  input  1  cancel a running conversion; the result is not updated.
- len  input  CNT_W  window length in valid stream bits; latched on accepted start.
- z_in  input  1  stochastic stream bit from the upstream polynomial block.
- z_valid  input  1  qualifies z_in for this cycle.
- stream_en  output  1  high in RUN; gates the upstream random sources and polynomial.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when a result is committed.
- ones  output  CNT_W  count of 1s from the last completed window; holds until the next completion.
- bits  output  CNT_W  window length of the last completed conversion.

Behaviour:
- Reset: asynchronous and active-high.
  - Asserting rst forces state=IDLE and stream_en=0, busy=0, done=0, ones=0, bits=0.
  - Internal counters and the latched length clear to 0.
  - Reset mid-RUN discards the partial window.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1, latch len into len_q and clear bit_cnt and one_cnt.
  - If len=0, go to DONE with one_cnt=0. Otherwise go to RUN.
- RUN:
  - stream_en=1.
  - Each cycle with z_valid=1: bit_cnt += 1 and one_cnt += z_in.
  - When a valid bit is accepted with bit_cnt == len_q-1, include that bit and go to DONE.
  - Cycles with z_valid=0 change nothing.
  - start is ignored in RUN.
- DONE (exactly one cycle):
  - done=1, ones <= one_cnt, bits <= len_q, stream_en=0.
  - Next state is IDLE.
  - A start arriving in DONE is ignored; it must be re-asserted in IDLE.
- abort:
  - Takes effect in RUN or DONE and returns to IDLE the next cycle.
  - done is not pulsed; ones and bits keep their previous values.
  - abort has priority over completion in the same cycle.
  - abort in IDLE has no effect, and has priority over start.
- Latency: done asserts one cycle after the clock edge that accepts the last valid bit. With z_valid held high and len=N, start is accepted on edge 0, the last bit is accepted on edge N, and done is high in the cycle after edge N.
- Width rules: one_cnt never exceeds len_q, so no overflow. Counters are unsigned with no wrap inside a window.
- The output probability estimate is ones/bits. Division is done off-block.

Optional Feature:
- Macro: SC_DECODE_BIPOLAR_EN.
- When defined:
  - Adds output `bipolar`, signed, CNT_W+1 bits.
  - Updated in DONE to 2*one_cnt - len_q (bipolar SC encoding, range -len_q..+len_q).
  - Reset value 0; holds like `ones`.
- When undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- len=8, z_valid=1, z_in pattern 1,0,1,1,0,0,1,0 -> done after 8 accepted bits; ones=4, bits=8, stream_en high for exactly 8 cycles; bipolar=0 if enabled.
- len=16, z_valid toggling 1,0,1,0,... with z_in=1 on every cycle -> completion at the 16th valid bit (~32 cycles); ones=16; bipolar=+16.
- len=0 with start -> DONE the next cycle; ones=0, bits=0; stream_en never asserts.
- len=100, abort at valid bit 50 -> IDLE, no done pulse, ones and bits retain the prior result; a new start with len=4, z_in all 0 gives ones=0, bipolar=-4.
- rst asserted asynchronously mid-RUN (between clock edges) -> all outputs 0 immediately; a new start with len=5, all 1s gives ones=5.
- start held high continuously with len=3, z_in=1 -> back-to-back conversions, each done pulse separated by one IDLE cycle; start pulses during RUN or DONE have no effect.

Source files
------------

// File: rtl/sc_stream_decoder_if.sv
// sc_stream_decoder_if: stream, handshake and result signals of the stochastic stream decoder.
// The bipolar result port exists only when SC_DECODE_BIPOLAR_EN is defined.
interface sc_stream_decoder_if #(parameter int CNT_W = 10);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] len;
    logic             z_in;
    logic             z_valid;
    logic             stream_en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] ones;
    logic [CNT_W-1:0] bits;
`ifdef SC_DECODE_BIPOLAR_EN
    logic signed [CNT_W:0] bipolar;
`endif
    modport master (
        output start, abort, len, z_in, z_valid,
`ifdef SC_DECODE_BIPOLAR_EN
        input bipolar,
`endif
        input stream_en, busy, done, ones, bits
    );
    modport slave (
        input start, abort, len, z_in, z_valid,
`ifdef SC_DECODE_BIPOLAR_EN
        output bipolar,
`endif
        output stream_en, busy, done, ones, bits
    );
endinterface

// File: rtl/sc_stream_decoder.sv
// sc_stream_decoder: counts 1s of a stochastic stream over a len-bit window and reports ones/bits.
// Define SC_DECODE_BIPOLAR_EN to add the signed bipolar result 2*ones - bits.
module sc_stream_decoder #(parameter int CNT_W = 10) (
    input logic clk,
    input logic rst,
    sc_stream_decoder_if.slave s
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;
    logic [CNT_W-1:0] len_q, bit_cnt, one_cnt;
    logic accept, last, commit;

    assign accept = state == IDLE && s.start && !s.abort;
    assign last = s.z_valid && bit_cnt == len_q - CNT_W'(1);

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state == IDLE ? (accept ? (s.len == '0 ? DONE : RUN) : IDLE) :
                    state == RUN  ? (s.abort ? IDLE : (last ? DONE : RUN)) : IDLE;
    end

    // abort landing in DONE suppresses the commit, so the previous result survives
    always_comb begin
        commit = state == DONE && !s.abort;
        s.stream_en = state == RUN;
        s.busy = state != IDLE;
        s.done = commit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q <= '0;
            bit_cnt <= '0;
            one_cnt <= '0;
            s.ones <= '0;
            s.bits <= '0;
        end else begin
            if (accept) begin
                len_q <= s.len;
                bit_cnt <= '0;
                one_cnt <= '0;
            end else if (state == RUN && s.z_valid && !s.abort) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
                one_cnt <= one_cnt + CNT_W'(s.z_in);
            end
            if (commit) begin
                s.ones <= one_cnt;
                s.bits <= len_q;
            end
        end
    end

`ifdef SC_DECODE_BIPOLAR_EN
    // modular CNT_W+1 subtraction is exact because the true result lies in -len_q..+len_q
    always_ff @(posedge clk or posedge rst)
        if (rst) s.bipolar <= '0;
        else if (commit) s.bipolar <= {one_cnt, 1'b0} - {1'b0, len_q};
`endif
endmodule

// File: tb/tb_sc_stream_decoder.sv
// tb_sc_stream_decoder: randomized scoreboard bench for sc_stream_decoder, with and without
// SC_DECODE_BIPOLAR_EN.
module tb_sc_stream_decoder;
    localparam int W = 10;
    typedef struct {int ones; int bits;} exp_t;

    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    sc_stream_decoder_if #(.CNT_W(W)) bus();
    sc_stream_decoder #(.CNT_W(W)) dut (.clk(clk), .rst(rst), .s(bus));

    exp_t q[$];
    exp_t pend_e, last_e;
    bit pend = 0;
    bit zbits[$];
    int done_cyc[$];
    int tests = 0, fails = 0, cyc = 0, en_cyc = 0;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // monitor: results appear on ones/bits the cycle after the done pulse
    always @(negedge clk) begin
        cyc++;
        if (bus.stream_en) en_cyc++;
        if (pend) begin
            pend = 0;
            chk("ones", bus.ones, pend_e.ones);
            chk("bits", bus.bits, pend_e.bits);
`ifdef SC_DECODE_BIPOLAR_EN
            chk("bipolar", bus.bipolar, 2 * pend_e.ones - pend_e.bits);
`endif
        end
        if (bus.done) begin
            done_cyc.push_back(cyc);
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected no done", cyc);
            end else begin
                pend_e = q.pop_front();
                pend = 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int n, input int kind);
        bit [7:0] p = 8'b1011_0010;
        zbits.delete();
        for (int i = 0; i < n; i++)
            zbits.push_back(kind == 0 ? 1'($urandom_range(0, 1)) : kind == 1 ? 1'b1 :
                            kind == 2 ? 1'b0 : p[7 - (i % 8)]);
    endtask

    // mode 0: z_valid always, 1: alternating, 2: random; abort_at >= 0 aborts on that valid bit
    task automatic run_conv(input int n, input int mode, input int abort_at);
        exp_t e;
        int k = 0, t = 0;
        bit v;
        e.ones = 0;
        e.bits = n;
        foreach (zbits[i]) e.ones += int'(zbits[i]);
        if (abort_at < 0) begin
            q.push_back(e);
            last_e = e;
        end
        bus.len = W'(n);
        bus.start = 1;
        step();
        bus.start = 0;
        while (k < n && t < 5000) begin
            v = mode == 0 || (mode == 1 && t % 2 == 0) || (mode == 2 && $urandom_range(0, 1) == 1);
            bus.z_valid = v;
            bus.z_in = v ? zbits[k] : 1'($urandom_range(0, 1));
            bus.abort = v && k == abort_at;
            step();
            t++;
            if (bus.abort) begin
                bus.abort = 0;
                bus.z_valid = 0;
                chk("abort_busy", bus.busy, 0);
                chk("abort_stream_en", bus.stream_en, 0);
                return;
            end
            if (v) k++;
        end
        bus.z_valid = 0;
        bus.z_in = 0;
        chk("done_latency", bus.done, 1);
        chk("done_stream_en", bus.stream_en, 0);
        step();
        chk("idle_after_done", bus.busy, 0);
    endtask

    initial begin
        int e0, n0;
        bus.start = 0;
        bus.abort = 0;
        bus.len = '0;
        bus.z_in = 0;
        bus.z_valid = 0;
        repeat (3) step();
        chk("rst_stream_en", bus.stream_en, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_ones", bus.ones, 0);
        chk("rst_bits", bus.bits, 0);
        #2 rst = 0;
        step();

        e0 = en_cyc;
        fill(8, 3);
        run_conv(8, 0, -1);
        chk("len8_stream_en_cycles", en_cyc - e0, 8);

        fill(16, 1);
        run_conv(16, 1, -1);

        fill(100, 0);
        run_conv(100, 0, 49);
        repeat (3) step();
        chk("abort_keeps_ones", bus.ones, last_e.ones);
        chk("abort_keeps_bits", bus.bits, last_e.bits);

        fill(4, 2);
        run_conv(4, 0, -1);

        e0 = en_cyc;
        fill(0, 0);
        run_conv(0, 0, -1);
        chk("len0_stream_en_cycles", en_cyc - e0, 0);

        // abort alone in IDLE, and abort beating start
        bus.abort = 1;
        step();
        bus.start = 1;
        bus.len = W'(5);
        step();
        bus.start = 0;
        bus.abort = 0;
        chk("abort_beats_start", bus.busy, 0);

        for (int i = 0; i < 15; i++) begin
            int n = $urandom_range(1, 40);
            fill(n, 0);
            run_conv(n, $urandom_range(0, 2), -1);
            step();
        end
        step();

        fill(9, 1);
        run_conv(9, 0, -1);
        bus.len = W'(20);
        bus.start = 1;
        step();
        bus.start = 0;
        bus.z_valid = 1;
        bus.z_in = 1;
        repeat (7) step();
        #2 rst = 1;
        #1;
        chk("arst_stream_en", bus.stream_en, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_ones", bus.ones, 0);
        chk("arst_bits", bus.bits, 0);
        bus.z_valid = 0;
        bus.z_in = 0;
        q.delete();
        #2 rst = 0;
        step();
        fill(5, 1);
        run_conv(5, 0, -1);

        n0 = done_cyc.size();
        for (int i = 0; i < 3; i++) q.push_back('{3, 3});
        bus.len = W'(3);
        bus.start = 1;
        bus.z_valid = 1;
        bus.z_in = 1;
        repeat (15) step();
        bus.start = 0;
        repeat (3) step();
        bus.z_valid = 0;
        chk("held_start_conversions", done_cyc.size() - n0, 3);
        for (int i = n0 + 1; i < done_cyc.size(); i++)
            chk("held_start_spacing", done_cyc[i] - done_cyc[i - 1], 5);

        fill(1023, 1);
        run_conv(1023, 0, -1);
        fill(1023, 0);
        run_conv(1023, 2, -1);
        repeat (3) step();
        chk("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
